// File: rtl/if_fetch.sv
// Instruction-fetch stage: one outstanding instruction-SRAM read, buffered bundle to ID.
// Optional IF_BYPASS_EN presents the returning word to ID in the same cycle it arrives.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_allowin_in,
  input  logic              id_valid_in,
  input  logic [ADDR_W-1:0] id_nextPC_in,
  output logic              if_valid_out,
  output logic [ADDR_W-1:0] if_PC_out,
  output logic [ADDR_W-1:0] if_NPC_out,
  output logic [ADDR_W-1:0] if_NNPC_out,
  output logic [31:0]       if_Instruct_out,
  output logic [ADDR_W-1:0] if_NPC_fast_out,
  output logic              if_adel_out,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [31:0]       inst_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_cur_pc;
  logic [ADDR_W-1:0] r_out_pc;
  logic [ADDR_W-1:0] r_out_npc;
  logic [ADDR_W-1:0] r_out_nnpc;
  logic [31:0]       r_inst;
  logic              r_valid;
  logic              r_adel;
  logic              r_drop;

  logic              w_misal;
  logic              w_resp;
  logic              w_byp;
  logic              w_fire;
  logic [ADDR_W-1:0] w_cur_npc;
  logic [ADDR_W-1:0] w_cur_nnpc;
  logic [ADDR_W-1:0] w_pc_npc;
  logic [ADDR_W-1:0] w_pc_nnpc;
  logic [ADDR_W-1:0] w_next_pc;

  assign w_misal    = (r_pc[1:0] != 2'b00);
  assign w_cur_npc  = r_cur_pc + ADDR_W'(4);
  assign w_cur_nnpc = r_cur_pc + ADDR_W'(8);
  assign w_pc_npc   = r_pc + ADDR_W'(4);
  assign w_pc_nnpc  = r_pc + ADDR_W'(8);
  assign w_resp     = (r_state == S_WAIT) && inst_data_ok && !r_drop;

`ifdef IF_BYPASS_EN
  assign w_byp = w_resp;
`else
  assign w_byp = 1'b0;
`endif

  assign if_valid_out    = r_valid | w_byp;
  assign w_fire          = if_valid_out && id_allowin_in;
  assign w_next_pc       = id_valid_in ? id_nextPC_in : w_cur_npc;

  assign if_PC_out       = w_byp ? r_cur_pc   : r_out_pc;
  assign if_NPC_out      = w_byp ? w_cur_npc  : r_out_npc;
  assign if_NNPC_out     = w_byp ? w_cur_nnpc : r_out_nnpc;
  assign if_Instruct_out = w_byp ? inst_rdata : r_inst;
  assign if_adel_out     = w_byp ? 1'b0       : r_adel;

  assign if_NPC_fast_out = ((r_state == S_WAIT) || (r_state == S_HOLD)) ? w_cur_npc : w_pc_npc;

  // A misaligned PC never reaches the SRAM; a stale response still owed blocks new requests.
  assign inst_req  = (r_state == S_REQ) && !r_drop && !w_misal;
  assign inst_addr = r_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_cur_pc   <= RESET_PC;
      r_valid    <= 1'b0;
      r_inst     <= '0;
      r_out_pc   <= '0;
      r_out_npc  <= '0;
      r_out_nnpc <= '0;
      r_adel     <= 1'b0;
      // Reset while a read is in flight: remember to swallow its response.
      r_drop     <= ((r_state == S_WAIT) || r_drop) && !inst_data_ok;
    end else begin
      if (r_drop && inst_data_ok) r_drop <= 1'b0;
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (w_misal) begin
            r_cur_pc   <= r_pc;
            r_out_pc   <= r_pc;
            r_out_npc  <= w_pc_npc;
            r_out_nnpc <= w_pc_nnpc;
            r_inst     <= '0;
            r_adel     <= 1'b1;
            r_valid    <= 1'b1;
            r_state    <= S_HOLD;
          end else if (!r_drop && inst_addr_ok) begin
            r_cur_pc <= r_pc;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_resp) begin
            r_inst     <= inst_rdata;
            r_out_pc   <= r_cur_pc;
            r_out_npc  <= w_cur_npc;
            r_out_nnpc <= w_cur_nnpc;
            r_adel     <= 1'b0;
            if (w_byp && id_allowin_in) begin
              r_pc    <= w_next_pc;
              r_state <= S_REQ;
            end else begin
              r_valid <= 1'b1;
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (w_fire) begin
            r_pc    <= w_next_pc;
            r_valid <= 1'b0;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: table of fetched bundles plus stall and reset-in-flight sequences.
module tb_if_fetch;

  localparam logic [31:0] K = 32'h1234_5678;
`ifdef IF_BYPASS_EN
  localparam int AL_GAP = 1;
`else
  localparam int AL_GAP = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_allowin_in, id_valid_in;
  logic [31:0] id_nextPC_in;
  logic        if_valid_out, if_adel_out, inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] if_PC_out, if_NPC_out, if_NNPC_out, if_Instruct_out, if_NPC_fast_out;
  logic [31:0] inst_addr, inst_rdata;

  logic        sram_on = 1'b0;
  logic        data_en = 1'b1;
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .id_allowin_in(id_allowin_in), .id_valid_in(id_valid_in), .id_nextPC_in(id_nextPC_in),
    .if_valid_out(if_valid_out), .if_PC_out(if_PC_out), .if_NPC_out(if_NPC_out),
    .if_NNPC_out(if_NNPC_out), .if_Instruct_out(if_Instruct_out),
    .if_NPC_fast_out(if_NPC_fast_out), .if_adel_out(if_adel_out),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata)
  );

  // Zero-wait SRAM model; data_en lets a test delay the response.
  assign inst_addr_ok = sram_on & inst_req;
  assign inst_data_ok = pend & data_en;
  assign inst_rdata   = paddr ^ K;

  always @(posedge clk) begin
    if (!sram_on) pend <= 1'b0;
    else begin
      if (inst_data_ok) pend <= 1'b0;
      if (inst_req && inst_addr_ok) begin
        pend  <= 1'b1;
        paddr <= inst_addr;
      end
    end
  end

  // Protocol monitor: no second request while one is owed, never a misaligned request.
  always @(negedge clk) begin
    if (sram_on && rst_n) begin
      total++;
      if (inst_req && (pend || inst_addr[1:0] != 2'b00 || if_valid_out)) begin
        bad++;
        $display("FAIL req_protocol: req=%b addr=%h pend=%b valid=%b, want no request", inst_req, inst_addr, pend, if_valid_out);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int gap);
    gap = 0;
    while (!if_valid_out && gap < 20) begin
      tick();
      gap++;
    end
    if (!if_valid_out) chk("valid_timeout", 32'(if_valid_out), 32'd1);
  endtask

  typedef struct {
    logic        idv;
    logic [31:0] nxt;
    logic [31:0] pc;
    logic        adel;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int gap;
    logic [31:0] exp_i;

    tbl[0] = '{1'b0, 32'h0,          32'hBFC00000, 1'b0};
    tbl[1] = '{1'b0, 32'h0,          32'hBFC00004, 1'b0};
    tbl[2] = '{1'b1, 32'hBFC00100,   32'hBFC00008, 1'b0};
    tbl[3] = '{1'b1, 32'hBFC00102,   32'hBFC00100, 1'b0};
    tbl[4] = '{1'b1, 32'hFFFFFFFC,   32'hBFC00102, 1'b1};
    tbl[5] = '{1'b0, 32'h0,          32'hFFFFFFFC, 1'b0};
    tbl[6] = '{1'b0, 32'h0,          32'h00000000, 1'b0};

    rst_n = 1'b0; id_allowin_in = 1'b0; id_valid_in = 1'b0; id_nextPC_in = '0;
    repeat (3) tick();
    chk("rst_valid", 32'(if_valid_out), 32'd0);
    chk("rst_req",   32'(inst_req), 32'd0);
    chk("rst_pc",    if_PC_out, 32'd0);
    chk("rst_npc",   if_NPC_out, 32'd0);
    chk("rst_nnpc",  if_NNPC_out, 32'd0);
    chk("rst_inst",  if_Instruct_out, 32'd0);
    chk("rst_adel",  32'(if_adel_out), 32'd0);
    chk("rst_fast",  if_NPC_fast_out, 32'hBFC00004);

    rst_n = 1'b1; sram_on = 1'b1; id_allowin_in = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_valid(gap);
      chk("gap", 32'(gap), 32'((tbl[i].adel ? 1 : AL_GAP) + (i == 0 ? 1 : 0)));
      exp_i = tbl[i].adel ? 32'd0 : (tbl[i].pc ^ K);
      chk("pc",   if_PC_out, tbl[i].pc);
      chk("npc",  if_NPC_out, tbl[i].pc + 32'd4);
      chk("nnpc", if_NNPC_out, tbl[i].pc + 32'd8);
      chk("fast", if_NPC_fast_out, tbl[i].pc + 32'd4);
      chk("inst", if_Instruct_out, exp_i);
      chk("adel", 32'(if_adel_out), 32'(tbl[i].adel));
`ifdef IF_BYPASS_EN
      if (!tbl[i].adel) chk("byp_rdata", if_Instruct_out, inst_rdata);
`endif
      id_valid_in = tbl[i].idv; id_nextPC_in = tbl[i].nxt;
      tick();
      id_valid_in = 1'b0;
      if (i < 6) chk("next_addr", inst_addr, tbl[i + 1].pc);
    end

    // ID stall: bundle must stay frozen and no request may go out.
    id_allowin_in = 1'b0;
    wait_valid(gap);
    chk("stall_gap", 32'(gap), 32'(AL_GAP));
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("stall_valid", 32'(if_valid_out), 32'd1);
      chk("stall_pc",    if_PC_out, 32'h4);
      chk("stall_npc",   if_NPC_out, 32'h8);
      chk("stall_inst",  if_Instruct_out, 32'h4 ^ K);
      chk("stall_req",   32'(inst_req), 32'd0);
    end
    id_allowin_in = 1'b1;
    tick();
    chk("one_xfer_valid", 32'(if_valid_out), 32'd0);
    chk("one_xfer_addr",  inst_addr, 32'h8);

    // Reset while the read of 0xC is in flight; its late response must be dropped.
    wait_valid(gap);
    chk("pre_rst_pc", if_PC_out, 32'h8);
    data_en = 1'b0;
    tick();
    chk("rw_req",  32'(inst_req), 32'd1);
    chk("rw_addr", inst_addr, 32'hC);
    tick();
    chk("wait_req",   32'(inst_req), 32'd0);
    chk("wait_valid", 32'(if_valid_out), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rw_valid", 32'(if_valid_out), 32'd0);
    chk("rw_pc",    if_PC_out, 32'd0);
    tick();
    chk("drop_req", 32'(inst_req), 32'd0);
    data_en = 1'b1;
    tick();
    chk("fresh_req",  32'(inst_req), 32'd1);
    chk("fresh_addr", inst_addr, 32'hBFC00000);
    wait_valid(gap);
    chk("fresh_pc",   if_PC_out, 32'hBFC00000);
    chk("fresh_inst", if_Instruct_out, 32'hBFC00000 ^ K);
    chk("fresh_adel", 32'(if_adel_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
